// File: rtl/red_pitaya_adc_decimator.sv
// Two-channel decimator / boxcar averager for the ADC user interface.
// Emits one sample pair per 2^K input cycles, either the frame average
// (floor rounding) or the last sample of the frame.
module red_pitaya_adc_decimator #(
    parameter int unsigned DW       = 14,
    parameter int unsigned MAX_LOG2 = 16
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] adc_a_i,
    input  logic [DW-1:0] adc_b_i,
    input  logic [4:0]    dec_log2_i,
    input  logic          avg_en_i,
    output logic [DW-1:0] dec_a_o,
    output logic [DW-1:0] dec_b_o,
    output logic          dec_vld_o,
    output logic [4:0]    dec_k_o
);

    localparam int unsigned AW  = DW + MAX_LOG2;
    localparam int unsigned CW  = MAX_LOG2;
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned KW  = 5;

    logic [CW-1:0]        cnt;
    logic                 avg_reg;
    logic signed [AW-1:0] acc_a;
    logic signed [AW-1:0] acc_b;

    logic                 frame_start_c;
    logic [KW-1:0]        k_in_c;
    logic [KW-1:0]        k_frm_c;
    logic                 avg_frm_c;
    logic [CW1-1:0]       last_cnt_c;
    logic                 last_c;
    logic signed [AW-1:0] samp_a_c;
    logic signed [AW-1:0] samp_b_c;
    logic signed [AW-1:0] sum_a_c;
    logic signed [AW-1:0] sum_b_c;

    // Frame configuration (fresh at frame start, held otherwise) and running sums
    always_comb begin
        frame_start_c = (cnt == '0);
        k_in_c        = (dec_log2_i > KW'(MAX_LOG2)) ? KW'(MAX_LOG2) : dec_log2_i;
        k_frm_c       = frame_start_c ? k_in_c : dec_k_o;
        avg_frm_c     = frame_start_c ? avg_en_i : avg_reg;
        last_cnt_c    = (CW1'(1) << k_frm_c) - CW1'(1);
        last_c        = ({1'b0, cnt} == last_cnt_c);
        samp_a_c      = {{MAX_LOG2{adc_a_i[DW-1]}}, adc_a_i};
        samp_b_c      = {{MAX_LOG2{adc_b_i[DW-1]}}, adc_b_i};
        sum_a_c       = frame_start_c ? samp_a_c : acc_a + samp_a_c;
        sum_b_c       = frame_start_c ? samp_b_c : acc_b + samp_b_c;
    end

    // Frame counter, accumulators and registered decimated outputs
    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            cnt       <= '0;
            avg_reg   <= 1'b0;
            acc_a     <= '0;
            acc_b     <= '0;
            dec_a_o   <= '0;
            dec_b_o   <= '0;
            dec_vld_o <= 1'b0;
            dec_k_o   <= '0;
        end else begin
            dec_k_o   <= k_frm_c;
            avg_reg   <= avg_frm_c;
            acc_a     <= sum_a_c;
            acc_b     <= sum_b_c;
            dec_vld_o <= last_c;
            if (last_c) begin
                cnt     <= '0;
                dec_a_o <= avg_frm_c ? DW'(sum_a_c >>> k_frm_c) : adc_a_i;
                dec_b_o <= avg_frm_c ? DW'(sum_b_c >>> k_frm_c) : adc_b_i;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_red_pitaya_adc_decimator.sv
// Directed bench for red_pitaya_adc_decimator.
module tb_red_pitaya_adc_decimator;

    logic        adc_clk_i;
    logic        adc_rst_i;
    logic [13:0] adc_a_i;
    logic [13:0] adc_b_i;
    logic [4:0]  dec_log2_i;
    logic        avg_en_i;
    logic [13:0] dec_a_o;
    logic [13:0] dec_b_o;
    logic        dec_vld_o;
    logic [4:0]  dec_k_o;

    int total = 0;
    int bad   = 0;

    red_pitaya_adc_decimator #(.DW(14), .MAX_LOG2(16)) dut (
        .adc_clk_i  (adc_clk_i),
        .adc_rst_i  (adc_rst_i),
        .adc_a_i    (adc_a_i),
        .adc_b_i    (adc_b_i),
        .dec_log2_i (dec_log2_i),
        .avg_en_i   (avg_en_i),
        .dec_a_o    (dec_a_o),
        .dec_b_o    (dec_b_o),
        .dec_vld_o  (dec_vld_o),
        .dec_k_o    (dec_k_o)
    );

    initial begin
        adc_clk_i = 1'b0;
        forever #5 adc_clk_i = ~adc_clk_i;
    end

    // One clock: outputs are observed 1 time unit after the rising edge
    task automatic tick();
        @(posedge adc_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic signed [13:0] r;
        int nv;

        // Reset
        adc_rst_i  = 1'b1;
        adc_a_i    = 14'd0;
        adc_b_i    = 14'd0;
        dec_log2_i = 5'd0;
        avg_en_i   = 1'b0;
        repeat (3) tick();
        chk("rst_a",   $signed(dec_a_o), 0);
        chk("rst_b",   $signed(dec_b_o), 0);
        chk("rst_vld", dec_vld_o, 0);
        chk("rst_k",   dec_k_o, 0);

        // K=0: pass-through with one cycle delay, strobe every cycle
        adc_rst_i = 1'b0;
        avg_en_i  = 1'b1;
        r = -14'sd8192;
        for (int i = 0; i < 4; i++) begin
            adc_a_i = r;
            adc_b_i = ~r;
            tick();
            chk("k0_vld", dec_vld_o, 1);
            chk("k0_a", $signed(dec_a_o), r);
            chk("k0_b", $signed(dec_b_o), ~r);
            r = r + 14'sd1;
        end
        r = 14'sd8186;
        for (int i = 0; i < 12; i++) begin
            adc_a_i = r;
            adc_b_i = ~r;
            tick();
            chk("k0_wrap_vld", dec_vld_o, 1);
            chk("k0_wrap_a", $signed(dec_a_o), r);
            r = r + 14'sd1;
        end
        chk("k0_k", dec_k_o, 0);

        // K=3: constant -1 averages to -1
        dec_log2_i = 5'd3;
        adc_a_i    = 14'h3fff;
        adc_b_i    = 14'h3fff;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) chk("k3_k", dec_k_o, 3);
            if (i < 7 && dec_vld_o) nv++;
        end
        chk("k3_early_vld", nv, 0);
        chk("k3_vld", dec_vld_o, 1);
        chk("k3_const_a", $signed(dec_a_o), -1);

        // K=3: ramp 0..7 -> 28/8 = 3; negative ramp -> floor(-3.5) = -4
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            adc_a_i = 14'(i);
            adc_b_i = 14'(-i);
            tick();
            if (i < 7 && dec_vld_o) nv++;
        end
        chk("k3_ramp_early_vld", nv, 0);
        chk("k3_ramp_vld", dec_vld_o, 1);
        chk("k3_ramp_a", $signed(dec_a_o), 3);
        chk("k3_ramp_b", $signed(dec_b_o), -4);
        adc_a_i = 14'd50;
        tick();
        chk("k3_hold_vld", dec_vld_o, 0);
        chk("k3_hold_a", $signed(dec_a_o), 3);
        // finish that frame so the next config is taken at frame start
        repeat (7) tick();
        chk("k3_fill_vld", dec_vld_o, 1);
        chk("k3_fill_a", $signed(dec_a_o), 50);

        // K=2: {-1,-1,-1,-2} -> floor(-5/4) = -2; {1,1,1,2} -> 1
        dec_log2_i = 5'd2;
        for (int i = 0; i < 4; i++) begin
            adc_a_i = (i == 3) ? 14'h3ffe : 14'h3fff;
            adc_b_i = (i == 3) ? 14'd2 : 14'd1;
            tick();
        end
        chk("k2_vld", dec_vld_o, 1);
        chk("k2_floor_a", $signed(dec_a_o), -2);
        chk("k2_b", $signed(dec_b_o), 1);

        // Requested K=20 clips to 16; full-scale sums must not overflow
        dec_log2_i = 5'd20;
        adc_a_i    = 14'h1fff;
        adc_b_i    = 14'h2000;
        nv = 0;
        for (int i = 0; i < 65536; i++) begin
            tick();
            if (i == 0) chk("k16_clip_k", dec_k_o, 16);
            if (i < 65535 && dec_vld_o) nv++;
        end
        chk("k16_early_vld", nv, 0);
        chk("k16_vld", dec_vld_o, 1);
        chk("k16_pos_a", $signed(dec_a_o), 8191);
        chk("k16_neg_b", $signed(dec_b_o), -8192);

        // K=4 no-avg; K request drops to 1 mid-frame and only applies next frame
        avg_en_i = 1'b0;
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            dec_log2_i = (i >= 5) ? 5'd1 : 5'd4;
            adc_a_i    = 14'(100 + i);
            adc_b_i    = 14'(-100 - i);
            tick();
            if (i < 15 && dec_vld_o) nv++;
        end
        chk("k4_early_vld", nv, 0);
        chk("k4_vld", dec_vld_o, 1);
        chk("k4_last_a", $signed(dec_a_o), 115);
        chk("k4_last_b", $signed(dec_b_o), -115);
        chk("k4_k", dec_k_o, 4);
        adc_a_i = 14'd200;
        tick();
        chk("k1_vld0", dec_vld_o, 0);
        chk("k1_k", dec_k_o, 1);
        adc_a_i = 14'd201;
        tick();
        chk("k1_vld1", dec_vld_o, 1);
        chk("k1_a", $signed(dec_a_o), 201);
        adc_a_i = 14'd202;
        tick();
        chk("k1_vld2", dec_vld_o, 0);
        adc_a_i = 14'd203;
        tick();
        chk("k1_vld3", dec_vld_o, 1);
        chk("k1_a2", $signed(dec_a_o), 203);

        // K=3 avg; reset at cnt=4 discards the partial frame
        dec_log2_i = 5'd3;
        avg_en_i   = 1'b1;
        adc_a_i    = 14'd1000;
        adc_b_i    = 14'd1000;
        repeat (4) tick();
        adc_rst_i = 1'b1;
        tick();
        chk("mrst_vld", dec_vld_o, 0);
        chk("mrst_a", $signed(dec_a_o), 0);
        chk("mrst_k", dec_k_o, 0);
        adc_rst_i = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            adc_a_i = 14'(2 * i);
            adc_b_i = 14'h3ffd;
            tick();
            if (i < 7 && dec_vld_o) nv++;
        end
        chk("mrst_early_vld", nv, 0);
        chk("mrst_post_vld", dec_vld_o, 1);
        chk("mrst_post_a", $signed(dec_a_o), 7);
        chk("mrst_post_b", $signed(dec_b_o), -3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
